pred_resolve_queue: RTL and testbench
=====================================

PRED_RESOLVE_QUEUE -- requirements
Module: pred_resolve_queue

Interface
REQ-001 Parameter DEPTH, default 4, entries in flight; power of two, 2..16.
REQ-002 Parameter ADDR_WIDTH, default 26, width of branch PC.
REQ-003 Parameter HIST_WIDTH, default 4, width of global-history snapshot.
REQ-004 clk  in  1  clock; all state updates on posedge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 alloc_valid  in  1  fetch made a prediction; push one entry.
REQ-007 alloc_pc  in  ADDR_WIDTH  PC of predicted instruction.
REQ-008 alloc_pred  in  1  predicted direction (1 = taken).
REQ-009 alloc_hist  in  HIST_WIDTH  history snapshot used for the prediction.
REQ-010 alloc_ready  out  1  queue not full.
REQ-011 res_valid  in  1  decode resolves the oldest entry; pop it.
REQ-012 res_is_branch  in  1  resolved instruction is a conditional branch.
REQ-013 res_taken  in  1  actual direction.
REQ-014 flush  in  1  discard all in-flight entries.
REQ-015 upd_we  out  1  predictor counter/history write enable.
REQ-016 upd_pc  out  ADDR_WIDTH  PC of resolved entry.
REQ-017 upd_pred  out  1  prediction stored for resolved entry.
REQ-018 upd_correct  out  1  1 when prediction matched outcome.
REQ-019 upd_hist  out  HIST_WIDTH  stored history snapshot.
REQ-020 mispredict  out  1  one-cycle pulse on branch mispredict.
REQ-021 count  out  clog2(DEPTH+1)  current occupancy.
REQ-022 err  out  1  sticky protocol error flag.

Function
REQ-023 Storage: circular FIFO, DEPTH entries of {pc, pred, hist}; head/tail pointers wrap modulo DEPTH; occupancy counter tracks 0..DEPTH.
REQ-024 alloc_ready = (count != DEPTH), combinational from registered count; pop in the same cycle does not raise it.
REQ-025 Push: alloc_valid & alloc_ready & ~flush writes entry at tail, tail+1 next cycle.
REQ-026 alloc_valid while full: entry dropped, state unchanged, err set.
REQ-027 Pop: res_valid & count!=0 reads head, head+1 next cycle, regardless of res_is_branch.
REQ-028 res_valid while empty (including same-cycle push into empty queue): ignored, err set; push still accepted.
REQ-029 Simultaneous accepted push and pop: count unchanged.
REQ-030 Update outputs registered, 1-cycle latency: cycle after valid pop, upd_we = res_is_branch; upd_pc/upd_pred/upd_hist = popped entry; upd_correct = ~(res_taken ^ stored pred); mispredict = res_is_branch & (res_taken != stored pred).
REQ-031 Cycles with no valid pop: upd_we=0, mispredict=0; upd_pc/upd_pred/upd_hist/upd_correct hold last values.
REQ-032 flush: valid pop in the same cycle is processed first (update emitted next cycle); then head=tail=0, count=0; same-cycle alloc dropped without err.
REQ-033 err sticky until reset; never cleared by flush.

Reset
REQ-034 rst_n=0 at posedge: head=tail=0, count=0, upd_we=0, mispredict=0, upd_pc=0, upd_pred=0, upd_correct=0, upd_hist=0, err=0; alloc_ready=1 next cycle.
REQ-035 Reset mid-operation discards all entries; inputs ignored during reset cycle.

Verification
REQ-036 Push pc=0x10 pred=1 hist=0xA, then res_valid is_branch=1 taken=0 -> next cycle upd_we=1, upd_pc=0x10, upd_pred=1, upd_correct=0, upd_hist=0xA, mispredict=1.
REQ-037 Push 4 entries (DEPTH=4) -> count=4, alloc_ready=0; 5th alloc -> dropped, err=1; pops return entries in push order.
REQ-038 Pop with is_branch=0 -> count decrements, upd_we=0, mispredict=0.
REQ-039 Push+pop same cycle at count=2 -> count stays 2; correct head entry emitted; 10 push/pop pairs exercise pointer wrap.
REQ-040 flush with res_valid and alloc_valid at count=3 -> oldest entry emitted next cycle, count=0, err=0.
REQ-041 res_valid on empty queue -> no upd_we, err=1; rst_n=0 -> err=0, count=0.

Source files
------------

// File: rtl/pred_resolve_queue.sv
// Branch prediction resolve queue: holds {pc, pred, hist} per in-flight prediction
// and emits a registered predictor update when decode resolves the oldest entry.
module pred_resolve_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 26,
    parameter int HIST_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         alloc_valid,
    input  logic [ADDR_WIDTH-1:0]        alloc_pc,
    input  logic                         alloc_pred,
    input  logic [HIST_WIDTH-1:0]        alloc_hist,
    output logic                         alloc_ready,
    input  logic                         res_valid,
    input  logic                         res_is_branch,
    input  logic                         res_taken,
    input  logic                         flush,
    output logic                         upd_we,
    output logic [ADDR_WIDTH-1:0]        upd_pc,
    output logic                         upd_pred,
    output logic                         upd_correct,
    output logic [HIST_WIDTH-1:0]        upd_hist,
    output logic                         mispredict,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [ADDR_WIDTH-1:0] mem_pc   [DEPTH];
    logic                  mem_pred [DEPTH];
    logic [HIST_WIDTH-1:0] mem_hist [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          push;
    logic          pop;
    logic          head_pred;

    // Handshake: an allocation is taken on a cycle where alloc_valid and alloc_ready
    // are both high and flush is low; res_valid has no ready and pops only if non-empty.
    assign alloc_ready = (count != FULL);

    always_comb begin
        push      = alloc_valid & alloc_ready & ~flush;
        pop       = res_valid & (count != '0);
        head_pred = mem_pred[head];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[tail]   <= alloc_pc;
            mem_pred[tail] <= alloc_pred;
            mem_hist[tail] <= alloc_hist;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            // Flush wins over pointer motion; the same-cycle pop still reaches the update regs.
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + PW'(1);
                if (pop)  head <= head + PW'(1);
                if (push && !pop)      count <= count + CW'(1);
                else if (pop && !push) count <= count - CW'(1);
            end
            if ((alloc_valid && !alloc_ready && !flush) || (res_valid && count == '0))
                err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            upd_we      <= 1'b0;
            mispredict  <= 1'b0;
            upd_pc      <= '0;
            upd_pred    <= 1'b0;
            upd_correct <= 1'b0;
            upd_hist    <= '0;
        end else begin
            upd_we     <= pop & res_is_branch;
            mispredict <= pop & res_is_branch & (res_taken != head_pred);
            if (pop) begin
                upd_pc      <= mem_pc[head];
                upd_pred    <= head_pred;
                upd_hist    <= mem_hist[head];
                upd_correct <= ~(res_taken ^ head_pred);
            end
        end
    end

endmodule

// File: tb/tb_pred_resolve_queue.sv
// Directed bench for pred_resolve_queue: per-scenario tasks with inline checks
// against an expected-entry queue.
module tb_pred_resolve_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 26;
    localparam int HW    = 4;
    localparam int CW    = $clog2(DEPTH+1);
    localparam int EW    = AW + 1 + HW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alloc_valid = 1'b0;
    logic [AW-1:0] alloc_pc = '0;
    logic          alloc_pred = 1'b0;
    logic [HW-1:0] alloc_hist = '0;
    logic          alloc_ready;
    logic          res_valid = 1'b0;
    logic          res_is_branch = 1'b0;
    logic          res_taken = 1'b0;
    logic          flush = 1'b0;
    logic          upd_we;
    logic [AW-1:0] upd_pc;
    logic          upd_pred;
    logic          upd_correct;
    logic [HW-1:0] upd_hist;
    logic          mispredict;
    logic [CW-1:0] count;
    logic          err;

    int total = 0;
    int bad   = 0;

    logic [EW-1:0] exp_q[$];

    pred_resolve_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .HIST_WIDTH(HW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_pred(alloc_pred),
        .alloc_hist(alloc_hist), .alloc_ready(alloc_ready),
        .res_valid(res_valid), .res_is_branch(res_is_branch), .res_taken(res_taken),
        .flush(flush),
        .upd_we(upd_we), .upd_pc(upd_pc), .upd_pred(upd_pred), .upd_correct(upd_correct),
        .upd_hist(upd_hist), .mispredict(mispredict), .count(count), .err(err)
    );

    always #5 clk = ~clk;

    // One clock with the given inputs; returns #1 after the edge with inputs idle.
    task automatic drive(input logic av, input logic [AW-1:0] pc, input logic pr,
                         input logic [HW-1:0] hi, input logic rv, input logic rb,
                         input logic rt, input logic fl);
        alloc_valid = av; alloc_pc = pc; alloc_pred = pr; alloc_hist = hi;
        res_valid = rv; res_is_branch = rb; res_taken = rt; flush = fl;
        @(posedge clk);
        #1;
        alloc_valid = 1'b0; res_valid = 1'b0; res_is_branch = 1'b0;
        res_taken = 1'b0; flush = 1'b0;
    endtask

    task automatic do_push(input logic [AW-1:0] pc, input logic pr, input logic [HW-1:0] hi);
        drive(1'b1, pc, pr, hi, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_pop(input logic rb, input logic rt);
        drive(1'b0, '0, 1'b0, '0, 1'b1, rb, rt, 1'b0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        drive(1'b1, 26'h3ff, 1'b1, 4'hf, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", alloc_ready); end
        total++; if ({upd_we, mispredict, err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {upd_we, mispredict, err}); end
        total++; if ({upd_pc, upd_pred, upd_correct, upd_hist} !== '0) begin bad++; $display("FAIL reset_upd got=%h exp=0", {upd_pc, upd_pred, upd_correct, upd_hist}); end
    endtask

    task automatic test_mispredict();
        do_push(26'h10, 1'b1, 4'hA);
        do_pop(1'b1, 1'b0);
        total++;
        if ({upd_we, upd_pc, upd_pred, upd_correct, upd_hist, mispredict} !== {1'b1, 26'h10, 1'b1, 1'b0, 4'hA, 1'b1}) begin
            bad++;
            $display("FAIL mispredict_upd got we=%b pc=%h pred=%b corr=%b hist=%h mis=%b exp 1 10 1 0 a 1",
                     upd_we, upd_pc, upd_pred, upd_correct, upd_hist, mispredict);
        end
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if ({upd_we, mispredict, upd_pc, upd_hist, count} !== {2'b00, 26'h10, 4'hA, CW'(0)}) begin
            bad++;
            $display("FAIL idle_hold got we=%b mis=%b pc=%h hist=%h cnt=%0d exp 0 0 10 a 0",
                     upd_we, mispredict, upd_pc, upd_hist, count);
        end
    endtask

    task automatic test_full();
        logic [EW-1:0] e;
        logic exp_corr;
        logic taken;
        for (int i = 0; i < DEPTH; i++) begin
            e = {AW'(26'h100 + i * 26'h44), 1'(i % 2), 4'(3 * i + 1)};
            exp_q.push_back(e);
            do_push(e[EW-1:HW+1], e[HW], e[HW-1:0]);
        end
        total++; if (count !== CW'(DEPTH) || alloc_ready !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL full_state got cnt=%0d rdy=%b err=%b exp 4 0 0", count, alloc_ready, err); end
        do_push(26'h3abcdef, 1'b1, 4'h5);
        total++; if (count !== CW'(DEPTH) || err !== 1'b1) begin bad++; $display("FAIL full_drop got cnt=%0d err=%b exp 4 1", count, err); end
        for (int i = 0; i < DEPTH; i++) begin
            e = exp_q.pop_front();
            taken = (i < 2) ? e[HW] : ~e[HW];
            exp_corr = ~(taken ^ e[HW]);
            do_pop(1'b1, taken);
            total++;
            if ({upd_we, upd_pc, upd_pred, upd_hist, upd_correct, mispredict} !== {1'b1, e, exp_corr, ~exp_corr}) begin
                bad++;
                $display("FAIL full_order[%0d] got pc=%h pred=%b hist=%h corr=%b mis=%b exp pc=%h pred=%b hist=%h corr=%b",
                         i, upd_pc, upd_pred, upd_hist, upd_correct, mispredict, e[EW-1:HW+1], e[HW], e[HW-1:0], exp_corr);
            end
        end
        total++; if (count !== '0 || alloc_ready !== 1'b1) begin bad++; $display("FAIL full_drain got cnt=%0d rdy=%b exp 0 1", count, alloc_ready); end
        apply_reset();
    endtask

    task automatic test_non_branch();
        do_push(26'h222, 1'b0, 4'h3);
        do_push(26'h333, 1'b1, 4'h6);
        do_pop(1'b0, 1'b1);
        total++;
        if ({count, upd_we, mispredict, upd_pc} !== {CW'(1), 2'b00, 26'h222}) begin
            bad++;
            $display("FAIL non_branch got cnt=%0d we=%b mis=%b pc=%h exp 1 0 0 222", count, upd_we, mispredict, upd_pc);
        end
        do_pop(1'b1, 1'b1);
        total++;
        if ({count, upd_we, mispredict, upd_correct, upd_pc} !== {CW'(0), 3'b101, 26'h333}) begin
            bad++;
            $display("FAIL non_branch_next got cnt=%0d we=%b mis=%b corr=%b pc=%h exp 0 1 0 1 333", count, upd_we, mispredict, upd_correct, upd_pc);
        end
    endtask

    task automatic test_back_to_back();
        logic [EW-1:0] e;
        logic [EW-1:0] n;
        for (int i = 0; i < 2; i++) begin
            e = {AW'(26'h500 + i), 1'(i), 4'(i + 8)};
            exp_q.push_back(e);
            do_push(e[EW-1:HW+1], e[HW], e[HW-1:0]);
        end
        for (int i = 0; i < 10; i++) begin
            n = {AW'($urandom_range(0, 26'h3ffffff)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
            exp_q.push_back(n);
            e = exp_q.pop_front();
            drive(1'b1, n[EW-1:HW+1], n[HW], n[HW-1:0], 1'b1, 1'b1, 1'b1, 1'b0);
            total++;
            if ({count, upd_we, upd_pc, upd_pred, upd_hist, mispredict} !== {CW'(2), 1'b1, e, ~e[HW]}) begin
                bad++;
                $display("FAIL b2b[%0d] got cnt=%0d pc=%h pred=%b hist=%h mis=%b exp cnt=2 pc=%h pred=%b hist=%h",
                         i, count, upd_pc, upd_pred, upd_hist, mispredict, e[EW-1:HW+1], e[HW], e[HW-1:0]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            do_pop(1'b1, 1'b0);
            total++;
            if ({upd_pc, upd_pred, upd_hist} !== e) begin bad++; $display("FAIL b2b_drain[%0d] got %h exp %h", i, {upd_pc, upd_pred, upd_hist}, e); end
        end
        total++; if (count !== '0 || err !== 1'b0) begin bad++; $display("FAIL b2b_end got cnt=%0d err=%b exp 0 0", count, err); end
    endtask

    task automatic test_flush();
        do_push(26'h700, 1'b0, 4'h1);
        do_push(26'h701, 1'b1, 4'h2);
        do_push(26'h702, 1'b0, 4'h3);
        drive(1'b1, 26'h7ff, 1'b1, 4'hf, 1'b1, 1'b1, 1'b1, 1'b1);
        total++;
        if ({upd_we, upd_pc, upd_pred, upd_hist, upd_correct, mispredict, count, err, alloc_ready} !==
            {1'b1, 26'h700, 1'b0, 4'h1, 1'b0, 1'b1, CW'(0), 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL flush got we=%b pc=%h pred=%b hist=%h corr=%b mis=%b cnt=%0d err=%b rdy=%b exp 1 700 0 1 0 1 0 0 1",
                     upd_we, upd_pc, upd_pred, upd_hist, upd_correct, mispredict, count, err, alloc_ready);
        end
        do_push(26'h7aa, 1'b1, 4'hc);
        do_pop(1'b1, 1'b1);
        total++;
        if ({upd_pc, upd_pred, upd_hist, upd_correct, count} !== {26'h7aa, 1'b1, 4'hc, 1'b1, CW'(0)}) begin
            bad++;
            $display("FAIL post_flush got pc=%h pred=%b hist=%h corr=%b cnt=%0d exp 7aa 1 c 1 0", upd_pc, upd_pred, upd_hist, upd_correct, count);
        end
    endtask

    task automatic test_empty_pop();
        do_pop(1'b1, 1'b0);
        total++; if ({upd_we, mispredict, err, count} !== {3'b001, CW'(0)}) begin bad++; $display("FAIL empty_pop got we=%b mis=%b err=%b cnt=%0d exp 0 0 1 0", upd_we, mispredict, err, count); end
        drive(1'b1, 26'h123, 1'b0, 4'h4, 1'b1, 1'b1, 1'b0, 1'b0);
        total++; if ({upd_we, err, count} !== {2'b01, CW'(1)}) begin bad++; $display("FAIL empty_push_pop got we=%b err=%b cnt=%0d exp 0 1 1", upd_we, err, count); end
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (err !== 1'b1 || count !== '0) begin bad++; $display("FAIL err_sticky got err=%b cnt=%0d exp 1 0", err, count); end
        do_push(26'h55, 1'b0, 4'h0);
        apply_reset();
        total++; if (err !== 1'b0 || count !== '0 || alloc_ready !== 1'b1) begin bad++; $display("FAIL err_reset got err=%b cnt=%0d rdy=%b exp 0 0 1", err, count, alloc_ready); end
    endtask

    initial begin
        test_reset();
        test_mispredict();
        test_full();
        test_non_branch();
        test_back_to_back();
        test_flush();
        test_empty_pop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
